// File: rtl/lsu_timer_slave.sv
// ============================================================================
// lsu_timer_slave
// ----------------------------------------------------------------------------
// Memory-mapped machine timer that sits on the core's LSU req/gnt/rvalid bus.
// It holds a free-running 64-bit MTIME with an 8-bit prescaler, a 64-bit
// MTIMECMP, a control register and a sticky pending flag. irq_o is a
// level-sensitive interrupt.
//
// Register map (byte offsets, only addr_i[11:0] decoded):
//   0x00 MTIME_LO     RW
//   0x04 MTIME_HI     RW
//   0x08 MTIMECMP_LO  RW
//   0x0C MTIMECMP_HI  RW
//   0x10 CTRL         RW  bit0 EN, bit1 IRQ_EN, bits[15:8] PRESC
//   0x14 STATUS       bit0 PEND, write-1-to-clear
//
// Parameters:
//   GNT_LATENCY  wait cycles a held request sees before gnt_o (0..3)
//   CMP_RESET    reset value of MTIMECMP
//
// Ports:
//   clk       clock, all state on the rising edge
//   rst_ni    asynchronous active-low reset
//   req_i     request valid from the LSU
//   gnt_o     request accepted (combinational in the grant cycle)
//   rvalid_o  response valid, one cycle after the grant
//   we_i      1 = write, 0 = read
//   be_i      byte enables
//   addr_i    byte address
//   wdata_i   write data
//   rdata_o   read data, valid with rvalid_o
//   err_o     response error, valid with rvalid_o
//   irq_o     timer interrupt (PEND & IRQ_EN), registered
// ============================================================================
module lsu_timer_slave #(
    parameter int unsigned GNT_LATENCY = 0,
    parameter logic [63:0] CMP_RESET   = 64'hFFFF_FFFF_FFFF_FFFF
) (
    input  logic        clk,
    input  logic        rst_ni,
    input  logic        req_i,
    output logic        gnt_o,
    output logic        rvalid_o,
    input  logic        we_i,
    input  logic [3:0]  be_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] rdata_o,
    output logic        err_o,
    output logic        irq_o
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    localparam bit         ZERO_LAT  = (GNT_LATENCY == 0);
    // The counter is loaded with LATENCY-1 on entry to WAIT and the grant
    // fires when it reaches zero, so WAIT lasts exactly GNT_LATENCY cycles.
    localparam logic [1:0] WAIT_LOAD = ZERO_LAT ? 2'd0 : 2'(GNT_LATENCY - 1);

    // ------------------------------------------------------------------
    // State and registers
    // ------------------------------------------------------------------
    state_t      r_state;
    state_t      w_stateNext;
    logic [1:0]  r_waitCnt;

    logic [63:0] r_mtime;
    logic [63:0] r_mtimecmp;
    logic        r_en;
    logic        r_irqEn;
    logic [7:0]  r_prescSel;
    logic [7:0]  r_prescCnt;
    logic        r_pend;
    logic        r_irq;

    logic [31:0] r_rdata;
    logic        r_err;

    // ------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------
    logic        w_grant;
    logic [11:0] w_offset;
    logic        w_selMtLo;
    logic        w_selMtHi;
    logic        w_selCmpLo;
    logic        w_selCmpHi;
    logic        w_selCtrl;
    logic        w_selStatus;
    logic        w_addrErr;
    logic        w_wrEn;
    logic [31:0] w_rdata;
    logic        w_tick;
    logic        w_cmpHit;
    logic        w_w1c;
    logic        w_pendNext;
    logic        w_irqEnNext;
    logic        w_unusedAddr;

    function automatic logic [31:0] mergeBytes(
        input logic [31:0] oldVal,
        input logic [31:0] newVal,
        input logic [3:0]  byteEn
    );
        logic [31:0] res;
        res = oldVal;
        for (int i = 0; i < 4; i++) begin
            if (byteEn[i]) begin
                res[i*8 +: 8] = newVal[i*8 +: 8];
            end
        end
        return res;
    endfunction

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state. RESP behaves like IDLE so requests can follow each
    // other without a bubble.
    // ------------------------------------------------------------------
    always_comb begin
        w_stateNext = r_state;
        case (r_state)
            ST_IDLE, ST_RESP: begin
                if (req_i) begin
                    w_stateNext = ZERO_LAT ? ST_RESP : ST_WAIT;
                end else begin
                    w_stateNext = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (!req_i) begin
                    w_stateNext = ST_IDLE;
                end else if (r_waitCnt == 2'd0) begin
                    w_stateNext = ST_RESP;
                end
            end
            default: w_stateNext = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs. The grant is gated by rst_ni so that a request held
    // across reset is never granted while the block is in reset.
    // ------------------------------------------------------------------
    always_comb begin
        w_grant  = 1'b0;
        rvalid_o = 1'b0;
        case (r_state)
            ST_IDLE: w_grant = req_i && ZERO_LAT;
            ST_WAIT: w_grant = req_i && (r_waitCnt == 2'd0);
            ST_RESP: begin
                rvalid_o = 1'b1;
                w_grant  = req_i && ZERO_LAT;
            end
            default: w_grant = 1'b0;
        endcase
        w_grant = w_grant & rst_ni;
    end

    assign gnt_o = w_grant;

    // Wait counter, loaded when entering WAIT.
    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            r_waitCnt <= 2'd0;
        end else if ((r_state != ST_WAIT) && (w_stateNext == ST_WAIT)) begin
            r_waitCnt <= WAIT_LOAD;
        end else if ((r_state == ST_WAIT) && (r_waitCnt != 2'd0)) begin
            r_waitCnt <= r_waitCnt - 2'd1;
        end
    end

    // ------------------------------------------------------------------
    // Address decode
    // ------------------------------------------------------------------
    assign w_offset     = addr_i[11:0];
    assign w_unusedAddr = ^addr_i[31:12];

    assign w_selMtLo   = (w_offset == 12'h000);
    assign w_selMtHi   = (w_offset == 12'h004);
    assign w_selCmpLo  = (w_offset == 12'h008);
    assign w_selCmpHi  = (w_offset == 12'h00C);
    assign w_selCtrl   = (w_offset == 12'h010);
    assign w_selStatus = (w_offset == 12'h014);

    assign w_addrErr = (addr_i[1:0] != 2'b00) ||
                       !(w_selMtLo || w_selMtHi || w_selCmpLo ||
                         w_selCmpHi || w_selCtrl || w_selStatus);

    assign w_wrEn = w_grant && we_i && !w_addrErr;

    // Read mux sees register values before this edge's update.
    always_comb begin
        w_rdata = 32'h0;
        if (w_selMtLo) begin
            w_rdata = r_mtime[31:0];
        end else if (w_selMtHi) begin
            w_rdata = r_mtime[63:32];
        end else if (w_selCmpLo) begin
            w_rdata = r_mtimecmp[31:0];
        end else if (w_selCmpHi) begin
            w_rdata = r_mtimecmp[63:32];
        end else if (w_selCtrl) begin
            w_rdata = {16'h0, r_prescSel, 6'h0, r_irqEn, r_en};
        end else if (w_selStatus) begin
            w_rdata = {31'h0, r_pend};
        end
    end

    // Response data is captured at the grant edge and held until the next grant.
    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            r_rdata <= 32'h0;
            r_err   <= 1'b0;
        end else if (w_grant) begin
            r_err   <= w_addrErr;
            r_rdata <= (w_addrErr || we_i) ? 32'h0 : w_rdata;
        end
    end

    assign rdata_o = r_rdata;
    assign err_o   = r_err;

    // ------------------------------------------------------------------
    // Prescaler: counts 0..PRESC, MTIME ticks on the wrap.
    // ------------------------------------------------------------------
    assign w_tick = r_en && (r_prescCnt == r_prescSel);

    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            r_prescCnt <= 8'h0;
        end else if (r_en) begin
            r_prescCnt <= w_tick ? 8'h0 : r_prescCnt + 8'd1;
        end
    end

    // A bus write to either half of MTIME wins over the tick in that cycle.
    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            r_mtime <= 64'h0;
        end else if (w_wrEn && w_selMtLo) begin
            r_mtime[31:0] <= mergeBytes(r_mtime[31:0], wdata_i, be_i);
        end else if (w_wrEn && w_selMtHi) begin
            r_mtime[63:32] <= mergeBytes(r_mtime[63:32], wdata_i, be_i);
        end else if (w_tick) begin
            r_mtime <= r_mtime + 64'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            r_mtimecmp <= CMP_RESET;
        end else if (w_wrEn && w_selCmpLo) begin
            r_mtimecmp[31:0] <= mergeBytes(r_mtimecmp[31:0], wdata_i, be_i);
        end else if (w_wrEn && w_selCmpHi) begin
            r_mtimecmp[63:32] <= mergeBytes(r_mtimecmp[63:32], wdata_i, be_i);
        end
    end

    // CTRL: byte 0 carries EN/IRQ_EN, byte 1 carries PRESC; bytes 2-3 are unused.
    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            r_en       <= 1'b0;
            r_irqEn    <= 1'b0;
            r_prescSel <= 8'h0;
        end else if (w_wrEn && w_selCtrl) begin
            if (be_i[0]) begin
                r_en    <= wdata_i[0];
                r_irqEn <= wdata_i[1];
            end
            if (be_i[1]) begin
                r_prescSel <= wdata_i[15:8];
            end
        end
    end

    // ------------------------------------------------------------------
    // Pending flag and interrupt. The compare looks at the registered
    // MTIME/MTIMECMP, so PEND rises one cycle after the condition first
    // holds. A live compare overrides a W1C.
    // ------------------------------------------------------------------
    assign w_cmpHit    = (r_mtime >= r_mtimecmp);
    assign w_w1c       = w_wrEn && w_selStatus && be_i[0] && wdata_i[0];
    assign w_pendNext  = w_cmpHit || (r_pend && !w_w1c);
    assign w_irqEnNext = (w_wrEn && w_selCtrl && be_i[0]) ? wdata_i[1] : r_irqEn;

    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            r_pend <= 1'b0;
            r_irq  <= 1'b0;
        end else begin
            r_pend <= w_pendNext;
            r_irq  <= w_pendNext && w_irqEnNext;
        end
    end

    assign irq_o = r_irq;

endmodule

// File: tb/tb_lsu_timer_slave.sv
// ============================================================================
// tb_lsu_timer_slave
// ----------------------------------------------------------------------------
// Directed bench with two instances: dutA uses GNT_LATENCY=0 and carries the
// timer tests, dutB uses GNT_LATENCY=2 for grant latency and reset-in-WAIT.
// A shared bus is steered to one instance by 'sel'.
// ============================================================================
module tb_lsu_timer_slave;

    logic        clk = 1'b0;
    logic        rstA_n;
    logic        rstB_n;
    logic        sel;
    logic        req;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;

    logic        gntA, rvalidA, errA, irqA;
    logic        gntB, rvalidB, errB, irqB;
    logic [31:0] rdataA, rdataB;
    logic        reqA, reqB;
    logic        gnt, rvalid, err;
    logic [31:0] rdata;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    assign reqA   = req & ~sel;
    assign reqB   = req & sel;
    assign gnt    = sel ? gntB    : gntA;
    assign rvalid = sel ? rvalidB : rvalidA;
    assign err    = sel ? errB    : errA;
    assign rdata  = sel ? rdataB  : rdataA;

    lsu_timer_slave #(.GNT_LATENCY(0)) dutA (
        .clk(clk), .rst_ni(rstA_n), .req_i(reqA), .gnt_o(gntA), .rvalid_o(rvalidA),
        .we_i(we), .be_i(be), .addr_i(addr), .wdata_i(wdata),
        .rdata_o(rdataA), .err_o(errA), .irq_o(irqA)
    );

    lsu_timer_slave #(.GNT_LATENCY(2)) dutB (
        .clk(clk), .rst_ni(rstB_n), .req_i(reqB), .gnt_o(gntB), .rvalid_o(rvalidB),
        .we_i(we), .be_i(be), .addr_i(addr), .wdata_i(wdata),
        .rdata_o(rdataB), .err_o(errB), .irq_o(irqB)
    );

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
        end
    endtask

    // One bus transaction, started just after a rising edge and returning
    // just after the edge that ends the response cycle.
    task automatic applyStimulus(input logic isWrite, input logic [31:0] a, input logic [31:0] d,
                                 input logic [3:0] byteEn, output logic [31:0] rd,
                                 output logic rerr, output int waitCyc);
        int cyc = 0;
        bit granted = 1'b0;
        req = 1'b1; we = isWrite; addr = a; wdata = d; be = byteEn;
        while (!granted && cyc < 10) begin
            @(negedge clk);
            cyc++;
            granted = gnt;
        end
        waitCyc = cyc;
        if (!granted) begin
            checkOutput("gntTimeout", 64'd0, 64'd1);
            req = 1'b0; we = 1'b0;
            rd = 32'h0; rerr = 1'b0;
            @(posedge clk); #1;
        end else begin
            @(posedge clk); #1;
            req = 1'b0; we = 1'b0;
            @(negedge clk);
            checkOutput("rvalid", {63'd0, rvalid}, 64'd1);
            rd = rdata;
            rerr = err;
            @(posedge clk); #1;
        end
    endtask

    task automatic writeReg(input logic [31:0] a, input logic [31:0] d, input logic [3:0] byteEn);
        logic [31:0] rd;
        logic        e;
        int          w;
        applyStimulus(1'b1, a, d, byteEn, rd, e, w);
    endtask

    task automatic readCheck(input string tag, input logic [31:0] a, input logic [31:0] exp);
        logic [31:0] rd;
        logic        e;
        int          w;
        applyStimulus(1'b0, a, 32'h0, 4'hF, rd, e, w);
        checkOutput(tag, {32'd0, rd}, {32'd0, exp});
    endtask

    // Hard stop in case something hangs outside the bounded waits.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [31:0] rd;
        logic        e;
        int          w;
        int          n;
        bit          seen;

        sel = 1'b0; req = 1'b0; we = 1'b0; be = 4'h0; addr = 32'h0; wdata = 32'h0;
        rstA_n = 1'b0; rstB_n = 1'b0;

        // Reset values, including a request held during reset.
        repeat (2) @(posedge clk);
        #1;
        req = 1'b1;
        #1;
        checkOutput("rstGnt",    {63'd0, gntA},    64'd0);
        checkOutput("rstRvalid", {63'd0, rvalidA}, 64'd0);
        checkOutput("rstErr",    {63'd0, errA},    64'd0);
        checkOutput("rstIrq",    {63'd0, irqA},    64'd0);
        checkOutput("rstRdata",  {32'd0, rdataA},  64'd0);
        req = 1'b0;
        @(posedge clk); #1;
        rstA_n = 1'b1; rstB_n = 1'b1;

        // First request after reset is granted in its first cycle.
        applyStimulus(1'b0, 32'h08, 32'h0, 4'hF, rd, e, w);
        checkOutput("firstGntCyc", w, 64'd1);
        checkOutput("cmpLoRst", {32'd0, rd}, 64'hFFFF_FFFF);
        readCheck("cmpHiRst",  32'h0C, 32'hFFFF_FFFF);
        readCheck("ctrlRst",   32'h10, 32'h0);
        readCheck("mtLoRst",   32'h00, 32'h0);
        readCheck("statusRst", 32'h14, 32'h0);

        // CTRL keeps only EN, IRQ_EN and PRESC.
        writeReg(32'h10, 32'hFFFF_FF00, 4'hF);
        readCheck("ctrlMask", 32'h10, 32'h0000_FF00);
        writeReg(32'h10, 32'h0, 4'hF);

        // PRESC=3: MTIME ticks every 4th edge after the CTRL write.
        writeReg(32'h10, 32'h0000_0301, 4'hF);
        repeat (14) @(posedge clk);
        #1;
        readCheck("presc3a", 32'h00, 32'd3);
        readCheck("presc3b", 32'h00, 32'd4);
        writeReg(32'h10, 32'h0, 4'hF);
        readCheck("frozenLo", 32'h00, 32'd5);
        readCheck("frozenHi", 32'h04, 32'd0);

        // Compare and interrupt: MTIME=5, PRESC=0, reaches 0x20 after 27 edges.
        writeReg(32'h0C, 32'h0, 4'hF);
        writeReg(32'h08, 32'h20, 4'hF);
        writeReg(32'h10, 32'h3, 4'hF);
        n = 0; seen = 1'b0;
        while (!seen && n < 100) begin
            @(negedge clk);
            n++;
            seen = irqA;
        end
        checkOutput("irqLatency", n, 64'd28);
        @(posedge clk); #1;
        writeReg(32'h14, 32'h1, 4'hF);
        checkOutput("irqAfterW1cHit", {63'd0, irqA}, 64'd1);
        readCheck("pendHeld", 32'h14, 32'h1);
        writeReg(32'h08, 32'hFFFF_FFFF, 4'hF);
        checkOutput("irqSticky", {63'd0, irqA}, 64'd1);
        writeReg(32'h14, 32'h1, 4'hF);
        checkOutput("irqCleared", {63'd0, irqA}, 64'd0);
        readCheck("pendCleared", 32'h14, 32'h0);
        writeReg(32'h10, 32'h0, 4'hF);

        // Carry into MTIME_HI; the LO write wins over the same-edge tick.
        writeReg(32'h10, 32'h1, 4'hF);
        writeReg(32'h04, 32'h0, 4'hF);
        writeReg(32'h00, 32'hFFFF_FFFF, 4'hF);
        readCheck("carryLo", 32'h00, 32'h0);
        readCheck("carryHi", 32'h04, 32'h1);
        writeReg(32'h10, 32'h0, 4'hF);
        readCheck("stopLo", 32'h00, 32'd5);
        writeReg(32'h00, 32'h1234_56AB, 4'b0001);
        readCheck("byteLo", 32'h00, 32'h0000_00AB);
        writeReg(32'h04, 32'hFFFF_FFFF, 4'b0100);
        readCheck("byteHi", 32'h04, 32'h00FF_0001);

        // Error responses leave state untouched.
        applyStimulus(1'b0, 32'h18, 32'h0, 4'hF, rd, e, w);
        checkOutput("unmappedErr",   {63'd0, e},  64'd1);
        checkOutput("unmappedRdata", {32'd0, rd}, 64'd0);
        applyStimulus(1'b0, 32'h02, 32'h0, 4'hF, rd, e, w);
        checkOutput("misalignErr",   {63'd0, e},  64'd1);
        checkOutput("misalignRdata", {32'd0, rd}, 64'd0);
        applyStimulus(1'b1, 32'h02, 32'hDEAD_BEEF, 4'hF, rd, e, w);
        checkOutput("misalignWrErr", {63'd0, e}, 64'd1);
        readCheck("noChangeLo", 32'h00, 32'h0000_00AB);
        applyStimulus(1'b1, 32'h0C, 32'hDEAD_BEEF, 4'h0, rd, e, w);
        checkOutput("beZeroErr", {63'd0, e}, 64'd0);
        readCheck("beZeroCmpHi", 32'h0C, 32'h0);

        // Back-to-back reads of 0x00 then 0x04.
        req = 1'b1; we = 1'b0; be = 4'hF; addr = 32'h00;
        @(negedge clk);
        checkOutput("b2bGnt0", {63'd0, gntA}, 64'd1);
        @(posedge clk); #1;
        addr = 32'h04;
        @(negedge clk);
        checkOutput("b2bRvalid0", {63'd0, rvalidA}, 64'd1);
        checkOutput("b2bData0",   {32'd0, rdataA},  64'h0000_00AB);
        checkOutput("b2bGnt1",    {63'd0, gntA},    64'd1);
        @(posedge clk); #1;
        req = 1'b0;
        @(negedge clk);
        checkOutput("b2bRvalid1", {63'd0, rvalidA}, 64'd1);
        checkOutput("b2bData1",   {32'd0, rdataA},  64'h00FF_0001);
        @(posedge clk); #1;

        // GNT_LATENCY=2: grant on the 3rd cycle of the request.
        sel = 1'b1;
        applyStimulus(1'b0, 32'h10, 32'h0, 4'hF, rd, e, w);
        checkOutput("lat2Cycles", w, 64'd3);
        checkOutput("lat2Rdata", {32'd0, rd}, 64'd0);
        checkOutput("lat2Err",   {63'd0, e},  64'd0);

        // Reset in the grant cycle of WAIT aborts the transaction.
        req = 1'b1; we = 1'b0; be = 4'hF; addr = 32'h10;
        @(posedge clk); #1;
        @(posedge clk); #1;
        checkOutput("waitGnt", {63'd0, gntB}, 64'd1);
        rstB_n = 1'b0;
        #1;
        checkOutput("rstWaitGnt",    {63'd0, gntB},    64'd0);
        checkOutput("rstWaitRvalid", {63'd0, rvalidB}, 64'd0);
        req = 1'b0;
        @(posedge clk); #1;
        rstB_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (rvalidB) seen = 1'b1;
        end
        checkOutput("noRvalidAfterRst", {63'd0, seen}, 64'd0);
        sel = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
